// File: rtl/tx_mode_sequencer.sv
// Steps the transmit core through a programmed mode table, inserting zero guard samples at
// each mode change. Defining TX_SEQ_LOOP_EN adds a loop_en input for continuous repetition.
module tx_mode_sequencer #(
   parameter int DEPTH     = 8,
   parameter int DW        = 16,
   parameter int GUARD_LEN = 4,
   parameter int SW        = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [3:0]               cfg_ctrl,
   input  logic [DW-1:0]            cfg_dwell,
   input  logic                     start,
   input  logic                     abort,
`ifdef TX_SEQ_LOOP_EN
   input  logic                     loop_en,
`endif
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] entry_idx,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [SW-1:0]            src_value,
   output logic [3:0]               io_ctrl,
   output logic [SW-1:0]            io_in_value
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GUARD_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GUARD = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    tbl_ctrl_q  [DEPTH];
   logic [3:0]    tbl_ctrl_d  [DEPTH];
   logic [DW-1:0] tbl_dwell_q [DEPTH];
   logic [DW-1:0] tbl_dwell_d [DEPTH];
   logic [AW-1:0] idx_q, idx_d;
   logic [GW-1:0] guard_q, guard_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic [SW-1:0] value_q, value_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          loop_s;
   logic          xfer_s;
   logic          last_s;

`ifdef TX_SEQ_LOOP_EN
   assign loop_s = loop_en;
`else
   assign loop_s = 1'b0;
`endif

   // Abort wins over a same-cycle transfer, so ready drops with it
   assign src_ready = (state_q == S_RUN) && !abort;
   assign xfer_s    = src_valid && src_ready;
   assign last_s    = (idx_q == AW'(DEPTH - 1));

   // Table write port, usable in every state
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         tbl_ctrl_d[i]  = (cfg_we && (cfg_addr == AW'(i))) ? cfg_ctrl  : tbl_ctrl_q[i];
         tbl_dwell_d[i] = (cfg_we && (cfg_addr == AW'(i))) ? cfg_dwell : tbl_dwell_q[i];
      end
   end

   // Sequencer next-state and registered output values
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      guard_d = guard_q;
      dwell_d = dwell_q;
      ctrl_d  = ctrl_q;
      value_d = value_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         value_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d = S_LOAD;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               if (tbl_dwell_q[idx_q] == '0) begin
                  // An empty entry 0 always ends the run so looping cannot spin on nothing
                  if (loop_s && (idx_q != '0)) begin
                     state_d = S_LOAD;
                     idx_d   = '0;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  state_d = S_GUARD;
                  ctrl_d  = tbl_ctrl_q[idx_q];
                  guard_d = GW'(GUARD_LEN);
                  dwell_d = tbl_dwell_q[idx_q];
                  value_d = '0;
               end
            end
            S_GUARD: begin
               if (guard_q <= GW'(1)) begin
                  state_d = S_RUN;
                  guard_d = '0;
               end else begin
                  guard_d = guard_q - GW'(1);
               end
            end
            S_RUN: begin
               if (xfer_s) begin
                  value_d = src_value;
                  dwell_d = dwell_q - DW'(1);
                  if (dwell_q == DW'(1)) begin
                     idx_d   = idx_q + AW'(1);
                     state_d = (last_s && !loop_s) ? S_DONE : S_LOAD;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               value_d = '0;
            end
            default: begin
               state_d = S_IDLE;
               value_d = '0;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State, table and output registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tbl_ctrl_q  <= '{default: 4'd0};
         tbl_dwell_q <= '{default: '0};
         idx_q       <= '0;
         guard_q     <= '0;
         dwell_q     <= '0;
         ctrl_q      <= 4'd0;
         value_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tbl_ctrl_q  <= tbl_ctrl_d;
         tbl_dwell_q <= tbl_dwell_d;
         idx_q       <= idx_d;
         guard_q     <= guard_d;
         dwell_q     <= dwell_d;
         ctrl_q      <= ctrl_d;
         value_q     <= value_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign entry_idx   = idx_q;
   assign io_ctrl     = ctrl_q;
   assign io_in_value = value_q;

endmodule

// File: tb/tb_tx_mode_sequencer.sv
// Directed bench for tx_mode_sequencer: reset, sequencing, backpressure, full table, table
// writes during a run, abort, and (with TX_SEQ_LOOP_EN) looping.
module tb_tx_mode_sequencer;
   localparam int SW = 12;

   logic          clock = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [2:0]    cfg_addr;
   logic [3:0]    cfg_ctrl;
   logic [15:0]   cfg_dwell;
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic [2:0]    entry_idx;
   logic          src_valid;
   logic          src_ready;
   logic [SW-1:0] src_value;
   logic [3:0]    io_ctrl;
   logic [SW-1:0] io_in_value;
`ifdef TX_SEQ_LOOP_EN
   logic          loop_en;
`endif

   int checks   = 0;
   int failures = 0;
   logic [SW-1:0] sine [128];

   tx_mode_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_ctrl   (cfg_ctrl),
      .cfg_dwell  (cfg_dwell),
      .start      (start),
      .abort      (abort),
`ifdef TX_SEQ_LOOP_EN
      .loop_en    (loop_en),
`endif
      .busy       (busy),
      .done       (done),
      .entry_idx  (entry_idx),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_value  (src_value),
      .io_ctrl    (io_ctrl),
      .io_in_value(io_in_value)
   );

   always #5 clock = ~clock;

   task automatic apply_reset();
      reset     = 1'b0;
      cfg_we    = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      src_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic write_entry(input int addr, input int ctrl, input int dwell);
      cfg_we    = 1'b1;
      cfg_addr  = 3'(addr);
      cfg_ctrl  = 4'(ctrl);
      cfg_dwell = 16'(dwell);
      @(negedge clock);
      cfg_we = 1'b0;
   endtask

   task automatic run_seq(output int n_xfer, output int n_done, output bit finished);
      n_xfer = 0;
      n_done = 0;
      finished = 1'b0;
      src_valid = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done) n_done++;
         if (n_done > 0 && !busy) begin
            finished = 1'b1;
            break;
         end
         if (src_valid && src_ready) n_xfer++;
         @(negedge clock);
      end
      src_valid = 1'b0;
   endtask

   task automatic test_reset();
      int nx, nd;
      bit fin;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || io_ctrl !== 4'd0 ||
          io_in_value !== '0 || entry_idx !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b rdy=%b ctrl=%0d val=%h idx=%0d exp all 0",
                  busy, done, src_ready, io_ctrl, io_in_value, entry_idx);
      end
      write_entry(0, 7, 100);
      src_valid = 1'b1;
      src_value = 12'h123;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      checks++;
      if (src_ready !== 1'b1 || io_ctrl !== 4'd7) begin
         failures++;
         $display("FAIL reset_prerun got rdy=%b ctrl=%0d exp rdy=1 ctrl=7", src_ready, io_ctrl);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || io_ctrl !== 4'd0 || io_in_value !== '0) begin
         failures++;
         $display("FAIL reset_midrun got busy=%b done=%b rdy=%b ctrl=%0d val=%h exp all 0",
                  busy, done, src_ready, io_ctrl, io_in_value);
      end
      reset = 1'b1;
      src_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || src_ready !== 1'b0 || io_ctrl !== 4'd0 || io_in_value !== '0) begin
         failures++;
         $display("FAIL reset_after got busy=%b rdy=%b ctrl=%0d val=%h exp all 0",
                  busy, src_ready, io_ctrl, io_in_value);
      end
      // table was cleared, so entry 0 is an end marker
      run_seq(nx, nd, fin);
      checks++;
      if (!fin || nx != 0 || nd != 1 || io_ctrl !== 4'd0) begin
         failures++;
         $display("FAIL reset_table_clear got fin=%0d xfers=%0d dones=%0d ctrl=%0d exp 1 0 1 0",
                  fin, nx, nd, io_ctrl);
      end
   endtask

   task automatic test_basic();
      int sent = 0, busy_cycles = 0, done_cnt = 0, nchg = 0;
      int zero_cnt [5];
      logic [3:0] modes [4];
      logic [3:0] last_ctrl;
      logic prev_xfer = 1'b0;
      logic [SW-1:0] prev_val = '0;
      bit seen_done = 1'b0, fin = 1'b0;
      for (int i = 0; i < 5; i++) zero_cnt[i] = 0;
      for (int i = 0; i < 4; i++) modes[i] = 4'd0;
      apply_reset();
      for (int k = 0; k < 4; k++) write_entry(k, k + 1, 512);
      write_entry(4, 9, 0);
      last_ctrl = io_ctrl;
      src_valid = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_xfer) begin
            checks++;
            if (io_in_value !== prev_val) begin
               failures++;
               $display("FAIL basic_data n=%0d got=%h exp=%h", sent - 1, io_in_value, prev_val);
            end
         end
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (io_ctrl !== last_ctrl) begin
            if (nchg < 4) modes[nchg] = io_ctrl;
            nchg++;
            last_ctrl = io_ctrl;
         end
         if (busy && !src_ready && !done && io_in_value == '0 && io_ctrl < 4'd5)
            zero_cnt[int'(io_ctrl)]++;
         if (done) seen_done = 1'b1;
         if (seen_done && !busy) begin
            fin = 1'b1;
            break;
         end
         src_value = sine[sent % 128];
         prev_xfer = src_valid && src_ready;
         if (prev_xfer) begin
            prev_val = src_value;
            sent++;
         end
         @(negedge clock);
      end
      src_valid = 1'b0;
      checks++;
      if (!fin || sent != 2048 || done_cnt != 1) begin
         failures++;
         $display("FAIL basic_count got fin=%0d samples=%0d dones=%0d exp 1 2048 1", fin, sent, done_cnt);
      end
      checks++;
      if (busy_cycles < 2069 || busy_cycles > 2071) begin
         failures++;
         $display("FAIL basic_busy got=%0d exp=2070+-1", busy_cycles);
      end
      for (int m = 0; m < 4; m++) begin
         checks++;
         if (modes[m] !== 4'(m + 1) || zero_cnt[m + 1] != 4) begin
            failures++;
            $display("FAIL basic_mode%0d got ctrl=%0d guard_zeros=%0d exp ctrl=%0d guard_zeros=4",
                     m, modes[m], zero_cnt[m + 1], m + 1);
         end
      end
      checks++;
      if (nchg != 4) begin
         failures++;
         $display("FAIL basic_mode_changes got=%0d exp=4", nchg);
      end
   endtask

   task automatic test_backpressure();
      int xfers = 0, bad_ctrl = 0;
      logic [SW-1:0] exp_io = '0;
      bit seen_done = 1'b0, fin = 1'b0;
      apply_reset();
      write_entry(0, 5, 10);
      src_valid = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (busy) begin
            checks++;
            if (io_in_value !== exp_io) begin
               failures++;
               $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, io_in_value, exp_io);
            end
         end
         if (src_ready && io_ctrl !== 4'd5) bad_ctrl++;
         if (done) seen_done = 1'b1;
         else if (seen_done) begin
            fin = 1'b1;
            break;
         end
         src_valid = 1'($urandom_range(0, 1));
         src_value = SW'($urandom);
         if (src_valid && src_ready) begin
            exp_io = src_value;
            xfers++;
         end
         @(negedge clock);
      end
      src_valid = 1'b0;
      checks++;
      if (!fin || xfers != 10) begin
         failures++;
         $display("FAIL bp_transfers got fin=%0d xfers=%0d exp 1 10", fin, xfers);
      end
      checks++;
      if (bad_ctrl != 0 || io_ctrl !== 4'd5 || io_in_value !== '0) begin
         failures++;
         $display("FAIL bp_ctrl got bad=%0d ctrl=%0d val=%h exp 0 5 0", bad_ctrl, io_ctrl, io_in_value);
      end
   endtask

   task automatic test_full_table();
      int xfers = 0, nidx = 0, done_cnt = 0, xfers_at_done = -1;
      logic [2:0] seq [8];
      logic [2:0] idx_at_done = 3'd7;
      bit fin = 1'b0;
      for (int i = 0; i < 8; i++) seq[i] = 3'd0;
      apply_reset();
      for (int i = 0; i < 8; i++) write_entry(i, i + 1, 3);
      src_valid = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (done) begin
            done_cnt++;
            xfers_at_done = xfers;
            idx_at_done = entry_idx;
         end
         if (done_cnt > 0 && !busy) begin
            fin = 1'b1;
            break;
         end
         if (src_ready && (nidx == 0 || entry_idx !== seq[(nidx - 1) % 8])) begin
            if (nidx < 8) seq[nidx] = entry_idx;
            nidx++;
         end
         if (src_valid && src_ready) xfers++;
         @(negedge clock);
      end
      src_valid = 1'b0;
      checks++;
      if (!fin || done_cnt != 1 || xfers_at_done != 24 || idx_at_done !== 3'd0) begin
         failures++;
         $display("FAIL full_done got fin=%0d dones=%0d xfers=%0d idx=%0d exp 1 1 24 0",
                  fin, done_cnt, xfers_at_done, idx_at_done);
      end
      checks++;
      if (nidx != 8) begin
         failures++;
         $display("FAIL full_idx_count got=%0d exp=8", nidx);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (seq[i] !== 3'(i)) begin
            failures++;
            $display("FAIL full_idx%0d got=%0d exp=%0d", i, seq[i], i);
         end
      end
   endtask

   task automatic test_table_write();
      int xf = 0, dn = 0, nx, nd;
      bit wrote = 1'b0, fin = 1'b0, fin2;
      apply_reset();
      write_entry(0, 3, 6);
      src_valid = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         cfg_we = 1'b0;
         if (done) dn++;
         if (dn > 0 && !busy) begin
            fin = 1'b1;
            break;
         end
         if (xf == 2 && !wrote && src_ready) begin
            cfg_we = 1'b1;
            cfg_addr = 3'd0;
            cfg_ctrl = 4'd3;
            cfg_dwell = 16'd2;
            wrote = 1'b1;
         end
         if (src_valid && src_ready) xf++;
         @(negedge clock);
      end
      cfg_we = 1'b0;
      src_valid = 1'b0;
      checks++;
      if (!fin || !wrote || xf != 6 || dn != 1) begin
         failures++;
         $display("FAIL twr_active got fin=%0d wrote=%0d xfers=%0d dones=%0d exp 1 1 6 1", fin, wrote, xf, dn);
      end
      run_seq(nx, nd, fin2);
      checks++;
      if (!fin2 || nx != 2 || nd != 1) begin
         failures++;
         $display("FAIL twr_reload got fin=%0d xfers=%0d dones=%0d exp 1 2 1", fin2, nx, nd);
      end
   endtask

   task automatic test_abort();
      bit found = 1'b0;
      int stray = 0;
      apply_reset();
      write_entry(0, 1, 5);
      write_entry(1, 2, 5);
      src_valid = 1'b1;
      src_value = 12'h7ff;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (io_ctrl == 4'd2) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      checks++;
      if (!found || src_ready !== 1'b0 || entry_idx !== 3'd1) begin
         failures++;
         $display("FAIL abort_guard1 got found=%0d rdy=%b idx=%0d exp 1 0 1", found, src_ready, entry_idx);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || io_in_value !== '0) begin
         failures++;
         $display("FAIL abort_idle got busy=%b done=%b rdy=%b val=%h exp 0 0 0 0",
                  busy, done, src_ready, io_in_value);
      end
      for (int c = 0; c < 10; c++) begin
         if (done || busy) stray++;
         @(negedge clock);
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL abort_no_done got=%0d exp=0", stray);
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || entry_idx !== 3'd0) begin
         failures++;
         $display("FAIL abort_restart got busy=%b idx=%0d exp 1 0", busy, entry_idx);
      end
      @(negedge clock);
      checks++;
      if (io_ctrl !== 4'd1) begin
         failures++;
         $display("FAIL abort_restart_ctrl got=%0d exp=1", io_ctrl);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      src_valid = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_start_same got busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

`ifdef TX_SEQ_LOOP_EN
   task automatic test_loop();
      int nchg = 0, dn = 0, nx, nd;
      logic [3:0] modes [6];
      logic [3:0] last_ctrl;
      bit fin;
      for (int i = 0; i < 6; i++) modes[i] = 4'd0;
      apply_reset();
      loop_en = 1'b1;
      write_entry(0, 1, 2);
      write_entry(1, 2, 2);
      last_ctrl = io_ctrl;
      src_valid = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (done) dn++;
         if (io_ctrl !== last_ctrl) begin
            if (nchg < 6) modes[nchg] = io_ctrl;
            nchg++;
            last_ctrl = io_ctrl;
         end
         @(negedge clock);
      end
      checks++;
      if (nchg < 6 || dn != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL loop_run got changes=%0d dones=%0d busy=%b exp >=6 0 1", nchg, dn, busy);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (modes[i] !== ((i % 2 == 0) ? 4'd1 : 4'd2)) begin
            failures++;
            $display("FAIL loop_mode%0d got=%0d exp=%0d", i, modes[i], (i % 2 == 0) ? 1 : 2);
         end
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      src_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL loop_abort got busy=%b done=%b exp 0 0", busy, done);
      end
      write_entry(0, 1, 0);
      run_seq(nx, nd, fin);
      checks++;
      if (!fin || nd != 1 || nx != 0) begin
         failures++;
         $display("FAIL loop_empty got fin=%0d dones=%0d xfers=%0d exp 1 1 0", fin, nd, nx);
      end
      loop_en = 1'b0;
   endtask
`endif

   initial begin
      cfg_addr  = 3'd0;
      cfg_ctrl  = 4'd0;
      cfg_dwell = 16'd0;
      src_value = '0;
`ifdef TX_SEQ_LOOP_EN
      loop_en = 1'b0;
`endif
      for (int i = 0; i < 128; i++) begin
         real r;
         r = 2047.0 * $sin(2.0 * 3.141592653589793 * i / 128.0);
         sine[i] = SW'($rtoi((r >= 0.0) ? (r + 0.5) : (r - 0.5)));
      end
      apply_reset();
      test_reset();
      test_basic();
      test_backpressure();
      test_full_table();
      test_table_write();
      test_abort();
`ifdef TX_SEQ_LOOP_EN
      test_loop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
